// File: rtl/noc_params.sv
// Shared NoC router types: flit format, labels, ports, VC width and input-block states.
package noc_params;

  localparam int VC_NUM         = 4;
  localparam int VC_SIZE        = $clog2(VC_NUM);
  localparam int FLIT_DATA_SIZE = 16;

  typedef enum logic [1:0] {HEAD, BODY, TAIL, HEADTAIL} flit_label_t;

  typedef enum logic [2:0] {LOCAL, NORTH, SOUTH, WEST, EAST} port_t;

  typedef enum logic [1:0] {IDLE, VA, SA} input_block_state_t;

  typedef struct packed {
    flit_label_t               flit_label;
    logic [FLIT_DATA_SIZE-1:0] payload;
  } flit_novc_t;

  function automatic logic is_head_label(input flit_label_t label);
    return (label == HEAD) || (label == HEADTAIL);
  endfunction

  function automatic logic is_tail_label(input flit_label_t label);
    return (label == TAIL) || (label == HEADTAIL);
  endfunction

endpackage

// File: rtl/circular_buffer.sv
// Flit FIFO with wrapping pointers; the front flit is presented combinationally on data_o.
module circular_buffer
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  flit_novc_t                   data_i,
  input  logic                         read_i,
  input  logic                         write_i,
  output flit_novc_t                   data_o,
  output logic                         is_full_o,
  output logic                         is_empty_o,
  output logic [$clog2(BUFFER_SIZE):0] occupancy_o
);

  localparam int PTR_W = $clog2(BUFFER_SIZE);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUFFER_SIZE - 1);

  flit_novc_t       mem [BUFFER_SIZE];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic             do_read;
  logic             do_write;

  // A read in the same cycle frees a slot, so a full FIFO still accepts a write.
  assign do_read  = read_i && !is_empty_o;
  assign do_write = write_i && (!is_full_o || do_read);

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr] <= data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_read)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
      if (do_write) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
      case ({do_write, do_read})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign data_o      = mem[rd_ptr];
  assign is_empty_o  = (count == '0);
  assign is_full_o   = (count == CNT_W'(BUFFER_SIZE));
  assign occupancy_o = count;

endmodule

// File: rtl/input_buffer.sv
// Router input port: one VC buffer with the IDLE/VA/SA packet FSM, route/VC latches
// and a registered error pulse for every illegal read or write.
module input_buffer
  import noc_params::*;
#(
  parameter int BUFFER_SIZE = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  flit_novc_t         data_i,
  input  logic               write_i,
  input  logic               read_i,
  input  port_t              out_port_i,
  input  logic               vc_valid_i,
  input  logic [VC_SIZE-1:0] vc_new_i,
  output flit_novc_t         data_o,
  output logic               is_full_o,
  output logic               is_empty_o,
  output logic               on_off_o,
  output port_t              out_port_o,
  output logic [VC_SIZE-1:0] downstream_vc_o,
  output logic               vc_request_o,
  output logic               switch_request_o,
  output logic               vc_allocatable_o,
  output logic               error_o
);

  localparam int OCC_W = $clog2(BUFFER_SIZE) + 1;

  input_block_state_t state;
  input_block_state_t next_state;
  logic [OCC_W-1:0]   occupancy;
  logic               rd_ok;
  logic               wr_ok;
  logic               head_in;

  // Heads are only legal in IDLE and body/tail flits only inside a packet.
  assign head_in = is_head_label(data_i.flit_label);
  assign rd_ok   = read_i && (state == SA) && !is_empty_o;
  assign wr_ok   = write_i && ((state == IDLE) == head_in) && (!is_full_o || rd_ok);

  circular_buffer #(
    .BUFFER_SIZE(BUFFER_SIZE)
  ) u_circular_buffer (
    .clk        (clk),
    .rst        (rst),
    .data_i     (data_i),
    .read_i     (rd_ok),
    .write_i    (wr_ok),
    .data_o     (data_o),
    .is_full_o  (is_full_o),
    .is_empty_o (is_empty_o),
    .occupancy_o(occupancy)
  );

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (wr_ok) next_state = VA;
      VA:      if (vc_valid_i) next_state = SA;
      SA:      if (rd_ok && is_tail_label(data_o.flit_label)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      out_port_o      <= LOCAL;
      downstream_vc_o <= '0;
      error_o         <= 1'b0;
    end else begin
      state <= next_state;
      if ((state == IDLE) && wr_ok) out_port_o <= out_port_i;
      if ((state == VA) && vc_valid_i) downstream_vc_o <= vc_new_i;
      error_o <= (write_i && !wr_ok) || (read_i && !rd_ok);
    end
  end

  assign on_off_o         = (occupancy < OCC_W'(BUFFER_SIZE - 2));
  assign vc_request_o     = (state == VA);
  assign switch_request_o = (state == SA) && !is_empty_o;
  assign vc_allocatable_o = (state == IDLE);

endmodule

// File: tb/tb_input_buffer.sv
// Bench for input_buffer: directed vector table, hand-written corner sequences
// and random traffic, all compared against a queue-based packet model.
module tb_input_buffer;
  import noc_params::*;

  localparam int BS = 8;

  logic               clk = 1'b0;
  logic               rst;
  flit_novc_t         data_i;
  logic               write_i;
  logic               read_i;
  port_t              out_port_i;
  logic               vc_valid_i;
  logic [VC_SIZE-1:0] vc_new_i;
  flit_novc_t         data_o;
  logic               is_full_o;
  logic               is_empty_o;
  logic               on_off_o;
  port_t              out_port_o;
  logic [VC_SIZE-1:0] downstream_vc_o;
  logic               vc_request_o;
  logic               switch_request_o;
  logic               vc_allocatable_o;
  logic               error_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  input_buffer #(.BUFFER_SIZE(BS)) dut (
    .clk             (clk),
    .rst             (rst),
    .data_i          (data_i),
    .write_i         (write_i),
    .read_i          (read_i),
    .out_port_i      (out_port_i),
    .vc_valid_i      (vc_valid_i),
    .vc_new_i        (vc_new_i),
    .data_o          (data_o),
    .is_full_o       (is_full_o),
    .is_empty_o      (is_empty_o),
    .on_off_o        (on_off_o),
    .out_port_o      (out_port_o),
    .downstream_vc_o (downstream_vc_o),
    .vc_request_o    (vc_request_o),
    .switch_request_o(switch_request_o),
    .vc_allocatable_o(vc_allocatable_o),
    .error_o         (error_o)
  );

  // Packet-level reference: a queue of stored flits plus the current packet phase.
  flit_novc_t         mq[$];
  input_block_state_t mst;
  port_t              mport;
  logic [VC_SIZE-1:0] mvc;
  logic               merr;

  typedef struct {
    logic               wr;
    flit_label_t        lbl;
    logic [15:0]        pl;
    logic               rd;
    port_t              op;
    logic               vv;
    logic [VC_SIZE-1:0] vn;
    logic               e_empty;
    logic               e_vcreq;
    logic               e_swreq;
    logic               e_alloc;
    logic               e_err;
    flit_label_t        e_front;
    port_t              e_port;
    logic [VC_SIZE-1:0] e_vc;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_update();
    logic hd, can_rd, can_wr;
    flit_novc_t front;
    if (rst) begin
      mq.delete();
      mst   = IDLE;
      mport = LOCAL;
      mvc   = '0;
      merr  = 1'b0;
      return;
    end
    hd     = data_i.flit_label inside {HEAD, HEADTAIL};
    can_rd = read_i && (mst == SA) && (mq.size() > 0);
    can_wr = write_i && ((mst == IDLE) ? hd : !hd) && ((mq.size() < BS) || can_rd);
    merr   = (write_i && !can_wr) || (read_i && !can_rd);
    front  = (mq.size() > 0) ? mq[0] : '0;
    if (mst == IDLE && can_wr) begin
      mst   = VA;
      mport = out_port_i;
    end else if (mst == VA && vc_valid_i) begin
      mst = SA;
      mvc = vc_new_i;
    end else if (mst == SA && can_rd && (front.flit_label inside {TAIL, HEADTAIL})) begin
      mst = IDLE;
    end
    if (can_rd) void'(mq.pop_front());
    if (can_wr) mq.push_back(data_i);
  endtask

  task automatic check_output();
    check("is_empty", is_empty_o, mq.size() == 0);
    check("is_full", is_full_o, mq.size() == BS);
    check("on_off", on_off_o, mq.size() < BS - 2);
    if (mq.size() > 0) check("data_o", data_o, mq[0]);
    check("out_port", out_port_o, mport);
    check("downstream_vc", downstream_vc_o, mvc);
    check("vc_request", vc_request_o, mst == VA);
    check("switch_request", switch_request_o, (mst == SA) && (mq.size() > 0));
    check("vc_allocatable", vc_allocatable_o, mst == IDLE);
    check("error", error_o, merr);
  endtask

  task automatic apply_stimulus(input logic r, input logic wr, input flit_label_t lbl,
                                input logic [15:0] pl, input logic rd, input port_t op,
                                input logic vv, input logic [VC_SIZE-1:0] vn);
    rst               = r;
    write_i           = wr;
    data_i.flit_label = lbl;
    data_i.payload    = pl;
    read_i            = rd;
    out_port_i        = op;
    vc_valid_i        = vv;
    vc_new_i          = vn;
    @(posedge clk);
    model_update();
    #1;
    check_output();
  endtask

  task automatic idle_cycle();
    apply_stimulus(1'b0, 1'b0, BODY, 16'h0, 1'b0, LOCAL, 1'b0, '0);
  endtask

  task automatic reset_cycle();
    apply_stimulus(1'b1, 1'b0, BODY, 16'h0, 1'b0, LOCAL, 1'b0, '0);
  endtask

  initial begin
    //           wr lbl       pl rd op     vv vn emp vq sw al er front     port   vc
    vecs[0]  = '{1, HEAD,     1, 0, EAST,  0, 0, 0,  1, 0, 0, 0, HEAD,     EAST,  0};
    vecs[1]  = '{1, BODY,     2, 0, LOCAL, 0, 0, 0,  1, 0, 0, 0, HEAD,     EAST,  0};
    vecs[2]  = '{1, TAIL,     3, 0, LOCAL, 0, 0, 0,  1, 0, 0, 0, HEAD,     EAST,  0};
    vecs[3]  = '{0, BODY,     0, 0, LOCAL, 1, 1, 0,  0, 1, 0, 0, HEAD,     EAST,  1};
    vecs[4]  = '{0, BODY,     0, 1, LOCAL, 0, 0, 0,  0, 1, 0, 0, BODY,     EAST,  1};
    vecs[5]  = '{0, BODY,     0, 1, LOCAL, 0, 0, 0,  0, 1, 0, 0, TAIL,     EAST,  1};
    vecs[6]  = '{0, BODY,     0, 1, LOCAL, 0, 0, 1,  0, 0, 1, 0, HEAD,     EAST,  1};
    vecs[7]  = '{1, BODY,     9, 0, LOCAL, 0, 0, 1,  0, 0, 1, 1, HEAD,     EAST,  1};
    vecs[8]  = '{0, BODY,     0, 0, LOCAL, 0, 0, 1,  0, 0, 1, 0, HEAD,     EAST,  1};
    vecs[9]  = '{1, HEAD,     4, 0, NORTH, 0, 0, 0,  1, 0, 0, 0, HEAD,     NORTH, 1};
    vecs[10] = '{0, BODY,     0, 1, LOCAL, 0, 0, 0,  1, 0, 0, 1, HEAD,     NORTH, 1};
    vecs[11] = '{0, BODY,     0, 0, LOCAL, 0, 0, 0,  1, 0, 0, 0, HEAD,     NORTH, 1};
    vecs[12] = '{0, BODY,     0, 0, LOCAL, 1, 2, 0,  0, 1, 0, 0, HEAD,     NORTH, 2};
    vecs[13] = '{0, BODY,     0, 1, LOCAL, 0, 0, 1,  0, 0, 0, 0, HEAD,     NORTH, 2};
    vecs[14] = '{1, HEADTAIL, 8, 0, SOUTH, 0, 0, 1,  0, 0, 0, 1, HEAD,     NORTH, 2};
    vecs[15] = '{1, TAIL,     5, 0, LOCAL, 0, 0, 0,  0, 1, 0, 0, TAIL,     NORTH, 2};
    vecs[16] = '{1, HEAD,     7, 1, SOUTH, 0, 0, 1,  0, 0, 1, 1, HEAD,     NORTH, 2};
    vecs[17] = '{1, HEADTAIL, 6, 0, WEST,  0, 0, 0,  1, 0, 0, 0, HEADTAIL, WEST,  2};
    vecs[18] = '{0, BODY,     0, 0, LOCAL, 1, 3, 0,  0, 1, 0, 0, HEADTAIL, WEST,  3};
    vecs[19] = '{0, BODY,     0, 1, LOCAL, 0, 0, 1,  0, 0, 1, 0, HEAD,     WEST,  3};

    reset_cycle();
    reset_cycle();
    check("rst_empty", is_empty_o, 1'b1);
    check("rst_full", is_full_o, 1'b0);
    check("rst_on_off", on_off_o, 1'b1);
    check("rst_port", out_port_o, LOCAL);
    check("rst_err", error_o, 1'b0);

    for (int i = 0; i < 20; i++) begin
      apply_stimulus(1'b0, vecs[i].wr, vecs[i].lbl, vecs[i].pl, vecs[i].rd, vecs[i].op,
                     vecs[i].vv, vecs[i].vn);
      check($sformatf("vec%0d_empty", i), is_empty_o, vecs[i].e_empty);
      check($sformatf("vec%0d_vcreq", i), vc_request_o, vecs[i].e_vcreq);
      check($sformatf("vec%0d_swreq", i), switch_request_o, vecs[i].e_swreq);
      check($sformatf("vec%0d_alloc", i), vc_allocatable_o, vecs[i].e_alloc);
      check($sformatf("vec%0d_err", i), error_o, vecs[i].e_err);
      check($sformatf("vec%0d_port", i), out_port_o, vecs[i].e_port);
      check($sformatf("vec%0d_vc", i), downstream_vc_o, vecs[i].e_vc);
      if (!vecs[i].e_empty) check($sformatf("vec%0d_front", i), data_o.flit_label, vecs[i].e_front);
    end

    // Fill to capacity, overflow once, then stream through a full buffer.
    reset_cycle();
    apply_stimulus(1'b0, 1'b1, HEAD, 16'h100, 1'b0, EAST, 1'b0, '0);
    check("fill1_on_off", on_off_o, 1'b1);
    for (int k = 1; k < BS; k++) begin
      apply_stimulus(1'b0, 1'b1, BODY, 16'(16'h100 + k), 1'b0, LOCAL, 1'b0, '0);
      check($sformatf("fill%0d_on_off", k + 1), on_off_o, (k + 1) < 6);
      check($sformatf("fill%0d_full", k + 1), is_full_o, (k + 1) == BS);
    end
    apply_stimulus(1'b0, 1'b1, BODY, 16'h1ff, 1'b0, LOCAL, 1'b0, '0);
    check("overflow_err", error_o, 1'b1);
    check("overflow_full", is_full_o, 1'b1);
    apply_stimulus(1'b0, 1'b0, BODY, 16'h0, 1'b0, LOCAL, 1'b1, 2'd1);
    for (int k = 0; k < 10; k++) begin
      apply_stimulus(1'b0, 1'b1, BODY, 16'(16'h200 + k), 1'b1, LOCAL, 1'b0, '0);
      check($sformatf("stream%0d_full", k), is_full_o, 1'b1);
      check($sformatf("stream%0d_err", k), error_o, 1'b0);
    end
    check("wrap_front", data_o.payload, 16'h202);
    for (int k = 0; k < 4; k++) apply_stimulus(1'b0, 1'b0, BODY, 16'h0, 1'b1, LOCAL, 1'b0, '0);
    check("four_left_front", data_o.payload, 16'h206);

    // Mid-packet reset must drop the stored flits and return to IDLE.
    reset_cycle();
    check("midrst_empty", is_empty_o, 1'b1);
    check("midrst_alloc", vc_allocatable_o, 1'b1);
    check("midrst_port", out_port_o, LOCAL);
    check("midrst_vc", downstream_vc_o, 2'd0);
    apply_stimulus(1'b0, 1'b1, HEAD, 16'h300, 1'b0, SOUTH, 1'b0, '0);
    check("post_rst_head_vcreq", vc_request_o, 1'b1);
    check("post_rst_head_err", error_o, 1'b0);
    check("post_rst_head_port", out_port_o, SOUTH);
    idle_cycle();

    for (int n = 0; n < 3000; n++) begin
      apply_stimulus($urandom_range(0, 99) == 0,
                     $urandom_range(0, 9) < 6,
                     flit_label_t'($urandom_range(0, 3)),
                     16'($urandom),
                     $urandom_range(0, 1) == 1,
                     port_t'($urandom_range(0, 4)),
                     $urandom_range(0, 1) == 1,
                     VC_SIZE'($urandom_range(0, VC_NUM - 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
